pe_select_arbiter: RTL and testbench
====================================

# pe_select_arbiter

Round-robin scheduler that shares the compute tile's 16-way select resource among 16 requesters. Each cycle it picks at most one requester and drives a registered 4-bit index plus a valid strobe. The index feeds the tile's 4-to-16 select decoder, and the valid strobe gates the decoded enables. Grants are held for a bounded burst, followed by a one-cycle turnaround gap before the next grant.

## Interface
- HOLD_MAX, 8: maximum grant length in cycles; legal range 1..16.
- PTR_RESET, 0: round-robin priority pointer value after reset; range 0..15.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  allows new grants; has no effect on a grant already in progress.
- req  in  16  level-sensitive requests, bit i = requester i.
- grant_idx  out  4  index of the granted requester, drives the decoder input.
- grant_valid  out  1  registered; high while a grant is active.
- xfer  out  1  combinational: grant_valid & req[grant_idx]; qualifies a transfer cycle.
- grant_done  out  1  one-cycle pulse in the gap cycle after each grant.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant active.
  - GAP: one dead cycle after each grant.
- Internal state: 4-bit pointer ptr and a hold counter cnt. cnt width is clog2(HOLD_MAX+1).
- Winner selection: the first i in the sequence ptr, ptr+1, …, ptr+15 (mod 16) with req[i]=1.
- IDLE or GAP, with en=1 and |req=1, at the clock edge:
  - grant_idx<=winner, grant_valid<=1, cnt<=1, state->BUSY.
- IDLE or GAP, otherwise: state->IDLE, grant_valid stays 0.
- BUSY, at the clock edge:
  - If req[grant_idx]=0 or cnt==HOLD_MAX: grant_valid<=0, grant_done<=1, ptr<=grant_idx+1 (wraps 15->0), state->GAP.
  - Else: cnt<=cnt+1.
- GAP: grant_done<=0 at the exit edge. GAP always lasts exactly one cycle.
- grant_idx holds the last granted value while grant_valid=0.
- Requests are not latched: a request dropped before it is granted is lost.
- A requester is re-granted after its own grant only if no other requester is pending.
- en=0 during BUSY: the current grant runs to completion, then the block goes to IDLE.
- Simultaneous requests: only the winner is granted; the others wait their turn in round-robin order.

## Timing
- Reset (async, immediate):
  - Outputs: grant_valid=0, grant_done=0, grant_idx=0, xfer=0.
  - Internal: state=IDLE, ptr=PTR_RESET, cnt=0.
- Reset asserted mid-grant: grant_valid drops without waiting for a clock edge. No grant_done pulse is generated.
- Request-to-grant latency:
  - req sampled at edge t -> grant_valid high from cycle t+1.
  - Minimum spacing between consecutive grants: one cycle with grant_valid=0.
- Grant length:
  - With req held high, grant_valid is high for exactly HOLD_MAX cycles.
  - With an early release, grant_valid also stays high for the first cycle in which req[grant_idx] is low. xfer is 0 in that tail cycle.
- Back-to-back throughput with saturated requests: one grant every HOLD_MAX+1 cycles.

## Test plan
All scenarios use HOLD_MAX=8 unless noted.
- Reset/idle:
  - Stimulus: rst_n low, then release with req=0 for 20 cycles.
  - Required: grant_valid, grant_done, xfer and grant_idx all 0 throughout.
- Single requester (PTR_RESET=0):
  - Stimulus: req=16'h0020 held from cycle 0.
  - Required: grant_idx=5 and grant_valid=1 in cycles 1-8; grant_done=1 in cycle 9; grant_valid=1 again in cycles 10-17.
- Saturation:
  - Stimulus: req=16'hFFFF held.
  - Required: grant_idx sequence 0,1,…,15,0; each grant 8 cycles long with a 1-cycle gap; period 9 cycles.
- Early release:
  - Stimulus: req[3] high in cycles 0-3, low from cycle 4.
  - Required: grant_valid in cycles 1-4, xfer in cycles 1-3, grant_done in cycle 5.
- Wrap-around:
  - Stimulus: after a grant to 14 (ptr=15), req bits 15 and 2 both high.
  - Required: grant 15 first, then 2.
- en gating and mid-grant reset:
  - en=0 with req=16'h00FF: no grant.
  - en raised -> grant_idx=0 on the next cycle.
  - en dropped during BUSY -> that grant completes, then the block returns to IDLE.
  - rst_n pulsed low in BUSY -> grant_valid=0 immediately, and the next grant starts from PTR_RESET.

Source files
------------

// File: rtl/pe_select_arbiter_if.sv
// rtl/pe_select_arbiter_if.sv - request/grant bundle between the requesters and pe_select_arbiter
//
// Ports:
//   en          requesters -> arbiter  allows new grants to start
//   req[15:0]   requesters -> arbiter  level-sensitive requests, bit i = requester i
//   grant_idx   arbiter -> requesters  granted index, feeds the 4-to-16 select decoder
//   grant_valid arbiter -> requesters  high while a grant is active
//   xfer        arbiter -> requesters  grant_valid qualified by the granted request
//   grant_done  arbiter -> requesters  one-cycle pulse in the gap after each grant

interface pe_select_arbiter_if;
    logic        en;
    logic [15:0] req;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        xfer;
    logic        grant_done;

    modport master (
        output en,
        output req,
        input  grant_idx,
        input  grant_valid,
        input  xfer,
        input  grant_done
    );

    modport slave (
        input  en,
        input  req,
        output grant_idx,
        output grant_valid,
        output xfer,
        output grant_done
    );
endinterface

// File: rtl/pe_select_arbiter.sv
// rtl/pe_select_arbiter.sv - 16-way round-robin arbiter with bounded bursts and a turnaround gap
//
// Parameters:
//   HOLD_MAX   maximum grant length in cycles (1..16)
//   PTR_RESET  round-robin pointer value after reset (0..15)
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pe_select_arbiter_if.slave (en, req in; grant_idx, grant_valid, xfer, grant_done out)

module pe_select_arbiter #(
    parameter int HOLD_MAX  = 8,
    parameter int PTR_RESET = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pe_select_arbiter_if.slave    bus
);

    localparam int             CW       = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0]  HOLD_CNT = CW'(HOLD_MAX);
    localparam logic [3:0]     PTR_INIT = 4'(PTR_RESET);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [3:0]     ptr, ptr_nxt;
    logic [3:0]     idx, idx_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           valid_q, valid_nxt;
    logic           done_q, done_nxt;

    logic [3:0]     winner;
    logic [3:0]     pos;
    logic           found;
    logic           any_req;
    logic           grant_end;

    // First requester at or after ptr, wrapping modulo 16. The 4-bit add
    // does the wrap for free.
    always_comb begin
        winner = ptr;
        pos    = ptr;
        found  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            pos = ptr + 4'(k);
            if (!found && bus.req[pos]) begin
                winner = pos;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |bus.req;

    // The cycle whose request is already low still counts as part of the
    // grant; the release is only seen at the edge that ends it.
    assign grant_end = !bus.req[idx] || (cnt == HOLD_CNT);

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= PTR_INIT;
            idx     <= 4'd0;
            cnt     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            valid_q <= valid_nxt;
            done_q  <= done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        case (state)
            IDLE, GAP: begin
                if (bus.en && any_req) begin
                    state_nxt = BUSY;
                    idx_nxt   = winner;
                    cnt_nxt   = CW'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (grant_end) begin
                    state_nxt = GAP;
                    // Moving past the just-served index keeps it at lowest
                    // priority, so it only wins again if nobody else asks.
                    ptr_nxt   = idx + 4'd1;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic: registered strobes follow the next state, xfer is live.
    always_comb begin
        valid_nxt = (state_nxt == BUSY);
        done_nxt  = (state_nxt == GAP);
        bus.xfer  = valid_q & bus.req[idx];
    end

    assign bus.grant_idx   = idx;
    assign bus.grant_valid = valid_q;
    assign bus.grant_done  = done_q;

endmodule

// File: tb/tb_pe_select_arbiter.sv
// tb/tb_pe_select_arbiter.sv - self-checking bench for pe_select_arbiter

module tb_pe_select_arbiter;

    logic clk;
    logic rst_n;

    pe_select_arbiter_if bus();

    pe_select_arbiter #(
        .HOLD_MAX  (8),
        .PTR_RESET (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic [15:0] req;
        logic        exp_valid;
        logic [3:0]  exp_idx;
        logic        exp_done;
        logic        exp_xfer;
    } vec_t;

    vec_t vecs[$];

    int checks;
    int errors;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int cyc, input logic v, input logic [3:0] i,
                             input logic d, input logic x);
        check({tag, ".grant_valid"}, cyc, 32'(bus.grant_valid), 32'(v));
        check({tag, ".grant_idx"},   cyc, 32'(bus.grant_idx),   32'(i));
        check({tag, ".grant_done"},  cyc, 32'(bus.grant_done),  32'(d));
        check({tag, ".xfer"},        cyc, 32'(bus.xfer),        32'(x));
    endtask

    task automatic add(input logic r, input logic e, input logic [15:0] q, input logic v,
                       input logic [3:0] i, input logic d, input logic x);
        vec_t t;
        t.rst_n = r; t.en = e; t.req = q;
        t.exp_valid = v; t.exp_idx = i; t.exp_done = d; t.exp_xfer = x;
        vecs.push_back(t);
    endtask

    // Leaves the bench 1 ns after a rising edge with the DUT in IDLE, ptr=0;
    // the cycle that follows is cycle 0 of the next scenario.
    task automatic do_reset();
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Early release of requester 3, then en gating and mid-grant reset.
        //   rst en  req       valid idx done xfer
        add(1, 1, 16'h0008,   0, 0, 0, 0);
        add(1, 1, 16'h0008,   1, 3, 0, 1);
        add(1, 1, 16'h0008,   1, 3, 0, 1);
        add(1, 1, 16'h0008,   1, 3, 0, 1);
        add(1, 1, 16'h0000,   1, 3, 0, 0);
        add(1, 1, 16'h0000,   0, 3, 1, 0);
        add(1, 1, 16'h0000,   0, 3, 0, 0);
        add(0, 0, 16'h00FF,   0, 0, 0, 0);
        add(1, 0, 16'h00FF,   0, 0, 0, 0);
        add(1, 0, 16'h00FF,   0, 0, 0, 0);
        add(1, 1, 16'h00FF,   0, 0, 0, 0);
        for (int k = 0; k < 8; k++)
            add(1, 0, 16'h00FF, 1, 0, 0, 1);
        add(1, 0, 16'h00FF,   0, 0, 1, 0);
        add(1, 0, 16'h00FF,   0, 0, 0, 0);
        add(1, 1, 16'h00FF,   0, 0, 0, 0);
        add(1, 1, 16'h00FF,   1, 1, 0, 1);
        add(0, 1, 16'h00FF,   0, 0, 0, 0);
        add(1, 1, 16'h00FF,   0, 0, 0, 0);
        add(1, 1, 16'h0001,   1, 0, 0, 1);
        add(1, 1, 16'h0000,   1, 0, 0, 0);
        add(1, 1, 16'h0000,   0, 0, 1, 0);

        // Reset value, checked while reset is still asserted.
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = 16'h0000;
        #3;
        check_all("reset", 0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Idle after reset with no requests.
        do_reset();
        bus.en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_all("idle", c, 1'b0, 4'd0, 1'b0, 1'b0);
            next_cycle();
        end

        // Table-driven sequence.
        do_reset();
        for (int n = 0; n < vecs.size(); n++) begin
            rst_n   = vecs[n].rst_n;
            bus.en  = vecs[n].en;
            bus.req = vecs[n].req;
            @(negedge clk);
            check_all("table", n, vecs[n].exp_valid, vecs[n].exp_idx, vecs[n].exp_done, vecs[n].exp_xfer);
            next_cycle();
        end

        // Single requester 5 held: two full bursts separated by one gap.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 16'h0020;
        for (int c = 0; c < 18; c++) begin
            logic v, d;
            logic [3:0] i;
            v = (c >= 1 && c <= 8) || (c >= 10 && c <= 17);
            d = (c == 9);
            i = (c == 0) ? 4'd0 : 4'd5;
            @(negedge clk);
            check_all("single", c, v, i, d, v);
            next_cycle();
        end

        // Saturation: indices 0..15 then 0 again, 8-cycle bursts, 9-cycle period.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 16'hFFFF;
        for (int c = 0; c < 1 + 17 * 9 - 1; c++) begin
            logic v, d;
            logic [3:0] i;
            if (c == 0) begin
                v = 1'b0; d = 1'b0; i = 4'd0;
            end else begin
                v = ((c - 1) % 9) < 8;
                d = ((c - 1) % 9) == 8;
                i = 4'(((c - 1) / 9) % 16);
            end
            @(negedge clk);
            check_all("saturate", c, v, i, d, v);
            next_cycle();
        end

        // Wrap-around: after a grant to 14 the pointer sits at 15, so 15
        // beats 2, then 2 goes next.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 16'h4000;
        next_cycle();
        bus.req = 16'h8004;
        @(negedge clk);
        check_all("wrap.g14", 1, 1'b1, 4'd14, 1'b0, 1'b0);
        next_cycle();
        @(negedge clk);
        check_all("wrap.gap", 2, 1'b0, 4'd14, 1'b1, 1'b0);
        next_cycle();
        @(negedge clk);
        check_all("wrap.g15", 3, 1'b1, 4'd15, 1'b0, 1'b1);
        repeat (8) next_cycle();
        @(negedge clk);
        check_all("wrap.gap2", 11, 1'b0, 4'd15, 1'b1, 1'b0);
        next_cycle();
        @(negedge clk);
        check_all("wrap.g2", 12, 1'b1, 4'd2, 1'b0, 1'b1);

        // Reset mid-grant must clear the outputs without a clock edge.
        next_cycle();
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 13, 1'b0, 4'd0, 1'b0, 1'b0);
        next_cycle();
        rst_n   = 1'b1;
        bus.req = 16'h00F0;
        next_cycle();
        @(negedge clk);
        check_all("post_rst", 15, 1'b1, 4'd4, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
